spi_rx_framer: RTL and testbench
================================

# spi_rx_framer

Downstream stage of the SPI master that converts its parallel receive frames into AXI-stream traffic. Each assertion of the SPI `data_valid` strobe captures one frame of `N_CHANNELS` words into a small frame FIFO. Frames are then emitted as one beat per channel with a per-channel `tdest`, so SPI ADC samples can be routed on the codebase's stream fabric. Drops are counted when the consumer stalls longer than the buffer can absorb.

## Interface
Parameters:
- `N_CHANNELS`, 3: words per SPI frame; matches the SPI `data_out` array length.
- `DATA_WIDTH`, 32: width of each word.
- `DEST_BASE`, 0: `tdest` of channel 0; channel k uses `DEST_BASE + k`.
- `FIFO_DEPTH`, 4: frames buffered. Must be a power of two, 2 to 16.

Ports (one clock; reset is synchronous and active-high):
- `clock` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `data_in[N_CHANNELS]` in `DATA_WIDTH` each: SPI `data_out` array.
- `data_valid` in 1: one-cycle frame strobe from SPI.
- `m_tdata` out `DATA_WIDTH`: output word.
- `m_tdest` out 8: `DEST_BASE` + channel index.
- `m_tlast` out 1: high on the last channel of a frame.
- `m_tvalid` out 1: output valid.
- `m_tready` in 1: consumer ready.
- `overflow` out 1: sticky; set on any dropped frame.
- `dropped_frames` out 16: saturating count of dropped frames.
- `clear_stats` in 1: single-cycle pulse; clears `overflow` and `dropped_frames`.

## Operation
- **Write side:**
  - On `data_valid`, if FIFO count < `FIFO_DEPTH`, all `N_CHANNELS` words are written as one entry.
  - Otherwise the frame is dropped: `overflow` is set and `dropped_frames` increments, saturating at 0xFFFF.
  - Fullness is evaluated on the pre-edge count. A pop in the same cycle does not rescue the frame.
- **Output FSM, IDLE:**
  - `m_tvalid` = 0.
  - If FIFO is non-empty: pop the head into the output frame register, set channel index = 0, go to SEND.
- **Output FSM, SEND:**
  - `m_tvalid` = 1.
  - `m_tdata` = frame[idx]; `m_tdest` = `DEST_BASE` + idx; `m_tlast` = (idx == `N_CHANNELS`-1).
  - Handshake (`m_tvalid` && `m_tready`) with idx < last: idx++.
  - Handshake on last beat with FIFO non-empty: pop the next frame on the same edge, idx = 0, stay in SEND (no bubble).
  - Handshake on last beat with FIFO empty: go to IDLE.
- Effective capacity is `FIFO_DEPTH` queued frames plus 1 in the output register.
- **AXI-stream rule:** while `m_tvalid` && !`m_tready`, `m_tdata`, `m_tdest` and `m_tlast` hold stable. `m_tvalid` never drops without a handshake.
- **`clear_stats` coincident with a drop:** the clear wins; the counter reads 0 and `overflow` reads 0.
- **`dest` width:** `DEST_BASE` + idx is truncated to 8 bits.

## Timing
- **Reset values:** `m_tvalid` 0, `m_tdata` 0, `m_tdest` 0, `m_tlast` 0, `overflow` 0, `dropped_frames` 0. FIFO is emptied and the FSM goes to IDLE.
- **Latency:** `data_valid` high in cycle t, FIFO empty, FSM idle → first beat has `m_tvalid` high in cycle t+2.
- **Throughput:** 1 beat/cycle with `m_tready` held high. Consecutive frames are emitted with no idle cycle.
- **Reset mid-frame:** partially sent and queued frames are discarded. `m_tvalid` is 0 in the cycle after the reset edge.
- **Stats:** `overflow` and `dropped_frames` update on the clock edge that samples the dropped `data_valid`.

## Configuration
- **Macro:** `SPI_RX_FRAMER_TIMESTAMP_EN`.
- **Defined:**
  - Adds output `m_tuser`, 32 bits, and a free-running 32-bit cycle counter that resets to 0 and wraps.
  - The counter value in the cycle `data_valid` is sampled is stored with the frame.
  - That value is presented on `m_tuser` for every beat of the frame and obeys the same stability rule.
- **Undefined:** no `m_tuser` port, no counter, no timestamp storage.

## Test plan
- **Single frame:** `data_in` = {0xCAFE, 0xBEEF, 0x1234}, one `data_valid` pulse, `m_tready` = 1 → beats at t+2, t+3, t+4 with `tdest` 0, 1, 2; `tlast` only on 0x1234.
- **Backpressure:** `m_tready` low for 5 cycles during beat 1 → `tdata` = 0xBEEF and `tdest` = 1 held stable; sequence resumes intact with no duplicate or lost beat.
- **Overflow:** `m_tready` = 0, 7 frames at 4-cycle spacing → 5 frames retained (4 queued + 1 in output register), `dropped_frames` = 2, `overflow` = 1. Release `m_tready` → 15 beats in order. A `clear_stats` pulse then zeroes both statistics.
- **Back-to-back:** two frames queued, `m_tready` = 1 → 6 consecutive valid cycles; `tlast` in cycles 3 and 6.
- **Reset mid-frame:** assert `reset` during beat 1 → `m_tvalid` is 0 the next cycle. A following frame restarts cleanly from `tdest` 0.
- **With `SPI_RX_FRAMER_TIMESTAMP_EN`:** frames sampled at counter values 100 and 140 → all three beats carry `m_tuser` 100 and 140 respectively.

Source files
------------

// File: rtl/spi_rx_framer.sv
// spi_rx_framer: buffers SPI receive frames in a small frame FIFO and replays them as
// AXI-stream beats, one per channel. Optional timestamp sideband: SPI_RX_FRAMER_TIMESTAMP_EN.
module spi_rx_framer #(
    parameter int N_CHANNELS = 3,
    parameter int DATA_WIDTH = 32,
    parameter int DEST_BASE  = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in [N_CHANNELS],
    input  logic                  data_valid,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic [7:0]            m_tdest,
    output logic                  m_tlast,
    output logic                  m_tvalid,
    input  logic                  m_tready,
`ifdef SPI_RX_FRAMER_TIMESTAMP_EN
    output logic [31:0]           m_tuser,
`endif
    output logic                  overflow,
    output logic [15:0]           dropped_frames,
    input  logic                  clear_stats
);
    localparam int IDX_W = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHANNELS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] frame_q [N_CHANNELS];
    logic [DATA_WIDTH-1:0] frame_d [N_CHANNELS];
    logic [DATA_WIDTH-1:0] mem_q   [FIFO_DEPTH][N_CHANNELS];
    logic [DATA_WIDTH-1:0] mem_d   [FIFO_DEPTH][N_CHANNELS];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic [15:0]           dropped_q, dropped_d;
    logic                  tvalid_q, tvalid_d;
    logic                  tlast_q, tlast_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic [7:0]            tdest_q, tdest_d;
    logic                  full_s, empty_s, push_s, drop_s, pop_s, hs_s, last_s;
    logic [31:0]           dest_sum_s;

    assign full_s  = (count_q == CNT_FULL);
    assign empty_s = (count_q == {CNT_W{1'b0}});

    // Frame admission, FIFO bookkeeping and drop statistics (fullness is the pre-edge count).
    always_comb begin
        push_s   = data_valid && !full_s;
        drop_s   = data_valid && full_s;
        wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        for (int e = 0; e < FIFO_DEPTH; e++) begin
            for (int k = 0; k < N_CHANNELS; k++) begin
                mem_d[e][k] = (push_s && (wr_ptr_q == PTR_W'(e))) ? data_in[k] : mem_q[e][k];
            end
        end
        if (clear_stats) begin
            overflow_d = 1'b0;
            dropped_d  = 16'h0000;
        end else if (drop_s) begin
            overflow_d = 1'b1;
            dropped_d  = (dropped_q == 16'hFFFF) ? dropped_q : (dropped_q + 16'h0001);
        end else begin
            overflow_d = overflow_q;
            dropped_d  = dropped_q;
        end
    end

    // Output FSM: pops a frame into the output register and walks its channels.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pop_s   = 1'b0;
        hs_s    = (state_q == ST_SEND) && m_tready;
        last_s  = (idx_q == LAST_IDX);
        case (state_q)
            ST_IDLE: begin
                if (!empty_s) begin
                    pop_s   = 1'b1;
                    idx_d   = IDX_ZERO;
                    state_d = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (hs_s && !last_s) begin
                    idx_d = idx_q + IDX_ONE;
                end else if (hs_s && !empty_s) begin
                    pop_s = 1'b1;
                    idx_d = IDX_ZERO;
                end else if (hs_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SEND;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = IDX_ZERO;
            end
        endcase
        for (int k = 0; k < N_CHANNELS; k++) begin
            frame_d[k] = pop_s ? mem_q[rd_ptr_q][k] : frame_q[k];
        end
        // Output registers only move when a beat is presented, so stalls hold them stable.
        dest_sum_s = 32'(DEST_BASE) + 32'(idx_d);
        tvalid_d   = (state_d == ST_SEND);
        if (tvalid_d) begin
            tdata_d = frame_d[idx_d];
            tdest_d = dest_sum_s[7:0];
            tlast_d = (idx_d == LAST_IDX);
        end else begin
            tdata_d = tdata_q;
            tdest_d = tdest_q;
            tlast_d = tlast_q;
        end
    end

    // Control, statistics and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= IDX_ZERO;
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            count_q    <= {CNT_W{1'b0}};
            overflow_q <= 1'b0;
            dropped_q  <= 16'h0000;
            tvalid_q   <= 1'b0;
            tdata_q    <= {DATA_WIDTH{1'b0}};
            tdest_q    <= 8'h00;
            tlast_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            dropped_q  <= dropped_d;
            tvalid_q   <= tvalid_d;
            tdata_q    <= tdata_d;
            tdest_q    <= tdest_d;
            tlast_q    <= tlast_d;
        end
    end

    // Frame storage; contents only matter where the pointers mark them valid.
    always_ff @(posedge clock) begin
        mem_q   <= mem_d;
        frame_q <= frame_d;
    end

    assign m_tvalid       = tvalid_q;
    assign m_tdata        = tdata_q;
    assign m_tdest        = tdest_q;
    assign m_tlast        = tlast_q;
    assign overflow       = overflow_q;
    assign dropped_frames = dropped_q;

`ifdef SPI_RX_FRAMER_TIMESTAMP_EN
    logic [31:0] ts_cnt_q, ts_cnt_d;
    logic [31:0] frame_ts_q, frame_ts_d;
    logic [31:0] tuser_q, tuser_d;
    logic [31:0] mem_ts_q [FIFO_DEPTH];
    logic [31:0] mem_ts_d [FIFO_DEPTH];

    // Stamp each admitted frame with the cycle count and carry it to the output beats.
    always_comb begin
        ts_cnt_d = ts_cnt_q + 32'd1;
        for (int e = 0; e < FIFO_DEPTH; e++) begin
            mem_ts_d[e] = (push_s && (wr_ptr_q == PTR_W'(e))) ? ts_cnt_q : mem_ts_q[e];
        end
        frame_ts_d = pop_s ? mem_ts_q[rd_ptr_q] : frame_ts_q;
        tuser_d    = tvalid_d ? frame_ts_d : tuser_q;
    end

    // Free-running stamp counter and tuser output register.
    always_ff @(posedge clock) begin
        if (reset) begin
            ts_cnt_q <= 32'd0;
            tuser_q  <= 32'd0;
        end else begin
            ts_cnt_q <= ts_cnt_d;
            tuser_q  <= tuser_d;
        end
    end

    // Timestamp storage beside the frame words.
    always_ff @(posedge clock) begin
        mem_ts_q   <= mem_ts_d;
        frame_ts_q <= frame_ts_d;
    end

    assign m_tuser = tuser_q;
`endif

endmodule

// File: tb/tb_spi_rx_framer.sv
// Self-checking bench for spi_rx_framer: expected beats are queued when frames are driven
// and compared as the DUT hands them off.
module tb_spi_rx_framer;
    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  dest;
        logic        last;
        logic [31:0] user;
    } beat_t;

`ifdef SPI_RX_FRAMER_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] data_in [3];
    logic        data_valid = 1'b0;
    logic [31:0] m_tdata;
    logic [7:0]  m_tdest;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic        overflow;
    logic [15:0] dropped_frames;
    logic        clear_stats = 1'b0;
    logic [31:0] obs_user;
    logic [31:0] tb_cycle = 32'd0;

    beat_t sb[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    spi_rx_framer #(
        .N_CHANNELS(3),
        .DATA_WIDTH(32),
        .DEST_BASE (0),
        .FIFO_DEPTH(4)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .data_in       (data_in),
        .data_valid    (data_valid),
        .m_tdata       (m_tdata),
        .m_tdest       (m_tdest),
        .m_tlast       (m_tlast),
        .m_tvalid      (m_tvalid),
        .m_tready      (m_tready),
`ifdef SPI_RX_FRAMER_TIMESTAMP_EN
        .m_tuser       (obs_user),
`endif
        .overflow      (overflow),
        .dropped_frames(dropped_frames),
        .clear_stats   (clear_stats)
    );

`ifndef SPI_RX_FRAMER_TIMESTAMP_EN
    assign obs_user = 32'd0;
`endif

    always #5 clock = ~clock;

    // Reference cycle count for expected timestamps.
    always @(posedge clock) begin
        if (reset) tb_cycle <= 32'd0;
        else       tb_cycle <= tb_cycle + 32'd1;
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] cur_ts();
        return TS_EN ? tb_cycle : 32'd0;
    endfunction

    // Drive one data_valid pulse; queue its beats if the frame is expected to be kept.
    task automatic send_frame(input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input bit keep, input logic [31:0] ts);
        logic [31:0] w [3];
        beat_t b;
        w[0] = w0; w[1] = w1; w[2] = w2;
        data_in[0] = w0; data_in[1] = w1; data_in[2] = w2;
        data_valid = 1'b1;
        if (keep) begin
            for (int k = 0; k < 3; k++) begin
                b.data = w[k];
                b.dest = 8'(k);
                b.last = (k == 2);
                b.user = ts;
                sb.push_back(b);
            end
        end
        tick;
        data_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick;
        tick;
        reset = 1'b0;
        n_checks++; if (m_tvalid !== 1'b0) $display("FAIL reset_tvalid got %b want 0", m_tvalid); else n_pass++;
        n_checks++; if (m_tdata !== 32'd0) $display("FAIL reset_tdata got %h want 0", m_tdata); else n_pass++;
        n_checks++; if (m_tdest !== 8'd0) $display("FAIL reset_tdest got %h want 0", m_tdest); else n_pass++;
        n_checks++; if (m_tlast !== 1'b0) $display("FAIL reset_tlast got %b want 0", m_tlast); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %b want 0", overflow); else n_pass++;
        n_checks++; if (dropped_frames !== 16'd0) $display("FAIL reset_dropped got %0d want 0", dropped_frames); else n_pass++;
    endtask

    task automatic test_single_frame;
        beat_t exp_b;
        m_tready = 1'b1;
        send_frame(32'hCAFE, 32'hBEEF, 32'h1234, 1'b1, cur_ts());
        n_checks++; if (m_tvalid !== 1'b0) $display("FAIL single_latency_t1 tvalid got %b want 0", m_tvalid); else n_pass++;
        tick;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (m_tvalid !== 1'b1) $display("FAIL single_tvalid beat %0d got %b want 1", i, m_tvalid); else n_pass++;
            if (m_tvalid && m_tready) begin
                n_checks++;
                if (sb.size() == 0) $display("FAIL single_beat unexpected tdata=%h", m_tdata);
                else begin
                    exp_b = sb.pop_front();
                    if (m_tdata !== exp_b.data || m_tdest !== exp_b.dest || m_tlast !== exp_b.last || obs_user !== exp_b.user)
                        $display("FAIL single_beat got %h/%0d/%b/%0d want %h/%0d/%b/%0d", m_tdata, m_tdest, m_tlast, obs_user,
                                 exp_b.data, exp_b.dest, exp_b.last, exp_b.user);
                    else n_pass++;
                end
            end
            tick;
        end
        n_checks++; if (m_tvalid !== 1'b0) $display("FAIL single_end tvalid got %b want 0", m_tvalid); else n_pass++;
    endtask

    task automatic test_backpressure;
        beat_t exp_b;
        m_tready = 1'b1;
        send_frame(32'h0011, 32'hBEEF, 32'h0033, 1'b1, cur_ts());
        tick;
        n_checks++;
        exp_b = sb.pop_front();
        if (m_tvalid !== 1'b1 || m_tdata !== exp_b.data || m_tdest !== exp_b.dest)
            $display("FAIL bp_beat0 got v=%b %h/%0d want v=1 %h/%0d", m_tvalid, m_tdata, m_tdest, exp_b.data, exp_b.dest);
        else n_pass++;
        tick;
        m_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (m_tvalid !== 1'b1 || m_tdata !== 32'hBEEF || m_tdest !== 8'd1 || m_tlast !== 1'b0)
                $display("FAIL bp_hold cycle %0d got v=%b %h/%0d/%b want v=1 0000beef/1/0", i, m_tvalid, m_tdata, m_tdest, m_tlast);
            else n_pass++;
            tick;
        end
        m_tready = 1'b1;
        for (int i = 0; i < 10 && sb.size() != 0; i++) begin
            if (m_tvalid && m_tready) begin
                n_checks++;
                exp_b = sb.pop_front();
                if (m_tdata !== exp_b.data || m_tdest !== exp_b.dest || m_tlast !== exp_b.last || obs_user !== exp_b.user)
                    $display("FAIL bp_beat got %h/%0d/%b want %h/%0d/%b", m_tdata, m_tdest, m_tlast, exp_b.data, exp_b.dest, exp_b.last);
                else n_pass++;
            end
            tick;
        end
        n_checks++; if (sb.size() != 0) $display("FAIL bp_drain left %0d beats want 0", sb.size()); else n_pass++;
        n_checks++; if (m_tvalid !== 1'b0) $display("FAIL bp_end tvalid got %b want 0 (duplicate beat)", m_tvalid); else n_pass++;
    endtask

    task automatic test_back_to_back;
        beat_t exp_b;
        m_tready = 1'b1;
        send_frame(32'hA0, 32'hA1, 32'hA2, 1'b1, cur_ts());
        send_frame(32'hB0, 32'hB1, 32'hB2, 1'b1, cur_ts());
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (m_tvalid !== 1'(i < 6) || (i < 6 && m_tlast !== 1'(i == 2 || i == 5)))
                $display("FAIL b2b_shape cycle %0d got v=%b last=%b want v=%b last=%b", i, m_tvalid, m_tlast,
                         1'(i < 6), 1'(i == 2 || i == 5));
            else n_pass++;
            if (m_tvalid && m_tready) begin
                n_checks++;
                if (sb.size() == 0) $display("FAIL b2b_beat unexpected tdata=%h", m_tdata);
                else begin
                    exp_b = sb.pop_front();
                    if (m_tdata !== exp_b.data || m_tdest !== exp_b.dest || m_tlast !== exp_b.last || obs_user !== exp_b.user)
                        $display("FAIL b2b_beat got %h/%0d/%b want %h/%0d/%b", m_tdata, m_tdest, m_tlast, exp_b.data, exp_b.dest, exp_b.last);
                    else n_pass++;
                end
            end
            tick;
        end
        n_checks++; if (sb.size() != 0) $display("FAIL b2b_drain left %0d beats want 0", sb.size()); else n_pass++;
    endtask

    task automatic test_overflow;
        beat_t exp_b;
        m_tready = 1'b0;
        for (int f = 0; f < 7; f++) begin
            send_frame(32'(f * 16 + 1), 32'(f * 16 + 2), 32'(f * 16 + 3), f < 5, cur_ts());
            if (f == 5) begin
                n_checks++;
                if (dropped_frames !== 16'd1 || overflow !== 1'b1)
                    $display("FAIL ovf_first_drop got cnt=%0d ovf=%b want 1/1", dropped_frames, overflow);
                else n_pass++;
            end
            tick; tick; tick;
        end
        n_checks++; if (dropped_frames !== 16'd2) $display("FAIL ovf_count got %0d want 2", dropped_frames); else n_pass++;
        n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_flag got %b want 1", overflow); else n_pass++;
        n_checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== 32'h1) $display("FAIL ovf_head got v=%b %h want v=1 00000001", m_tvalid, m_tdata);
        else n_pass++;
        m_tready = 1'b1;
        for (int i = 0; i < 25 && sb.size() != 0; i++) begin
            if (m_tvalid && m_tready) begin
                n_checks++;
                exp_b = sb.pop_front();
                if (m_tdata !== exp_b.data || m_tdest !== exp_b.dest || m_tlast !== exp_b.last || obs_user !== exp_b.user)
                    $display("FAIL ovf_beat got %h/%0d/%b want %h/%0d/%b", m_tdata, m_tdest, m_tlast, exp_b.data, exp_b.dest, exp_b.last);
                else n_pass++;
            end
            tick;
        end
        n_checks++; if (sb.size() != 0) $display("FAIL ovf_drain left %0d beats want 0", sb.size()); else n_pass++;
        n_checks++; if (m_tvalid !== 1'b0) $display("FAIL ovf_end tvalid got %b want 0", m_tvalid); else n_pass++;
        clear_stats = 1'b1;
        tick;
        clear_stats = 1'b0;
        n_checks++;
        if (dropped_frames !== 16'd0 || overflow !== 1'b0) $display("FAIL ovf_clear got %0d/%b want 0/0", dropped_frames, overflow);
        else n_pass++;
        // Refill, drop one, then drop another while clearing: the clear must win.
        m_tready = 1'b0;
        for (int f = 0; f < 6; f++) begin
            send_frame(32'(f + 32'h100), 32'(f + 32'h200), 32'(f + 32'h300), f < 5, cur_ts());
            tick;
        end
        n_checks++; if (dropped_frames !== 16'd1) $display("FAIL clr_pre got %0d want 1", dropped_frames); else n_pass++;
        clear_stats = 1'b1;
        send_frame(32'hDEAD, 32'hDEAD, 32'hDEAD, 1'b0, cur_ts());
        clear_stats = 1'b0;
        n_checks++;
        if (dropped_frames !== 16'd0 || overflow !== 1'b0) $display("FAIL clr_wins got %0d/%b want 0/0", dropped_frames, overflow);
        else n_pass++;
        m_tready = 1'b1;
        for (int i = 0; i < 25 && sb.size() != 0; i++) begin
            if (m_tvalid && m_tready) begin
                n_checks++;
                exp_b = sb.pop_front();
                if (m_tdata !== exp_b.data || m_tdest !== exp_b.dest || m_tlast !== exp_b.last || obs_user !== exp_b.user)
                    $display("FAIL clr_beat got %h/%0d/%b want %h/%0d/%b", m_tdata, m_tdest, m_tlast, exp_b.data, exp_b.dest, exp_b.last);
                else n_pass++;
            end
            tick;
        end
        n_checks++; if (sb.size() != 0) $display("FAIL clr_drain left %0d beats want 0", sb.size()); else n_pass++;
    endtask

    task automatic test_reset_mid_frame;
        beat_t exp_b;
        m_tready = 1'b1;
        send_frame(32'h51, 32'h52, 32'h53, 1'b1, cur_ts());
        tick;
        n_checks++;
        exp_b = sb.pop_front();
        if (m_tvalid !== 1'b1 || m_tdata !== exp_b.data) $display("FAIL rst_beat0 got v=%b %h want v=1 %h", m_tvalid, m_tdata, exp_b.data);
        else n_pass++;
        tick;
        reset = 1'b1;
        n_checks++;
        if (m_tvalid !== 1'b1 || m_tdest !== 8'd1) $display("FAIL rst_beat1 got v=%b dest=%0d want v=1 dest=1", m_tvalid, m_tdest);
        else n_pass++;
        tick;
        reset = 1'b0;
        sb.delete();
        n_checks++; if (m_tvalid !== 1'b0) $display("FAIL rst_tvalid got %b want 0", m_tvalid); else n_pass++;
        send_frame(32'h61, 32'h62, 32'h63, 1'b1, cur_ts());
        for (int i = 0; i < 10 && sb.size() != 0; i++) begin
            if (m_tvalid && m_tready) begin
                n_checks++;
                exp_b = sb.pop_front();
                if (m_tdata !== exp_b.data || m_tdest !== exp_b.dest || m_tlast !== exp_b.last || obs_user !== exp_b.user)
                    $display("FAIL rst_restart got %h/%0d/%b want %h/%0d/%b", m_tdata, m_tdest, m_tlast, exp_b.data, exp_b.dest, exp_b.last);
                else n_pass++;
            end
            tick;
        end
        n_checks++; if (sb.size() != 0) $display("FAIL rst_drain left %0d beats want 0", sb.size()); else n_pass++;
    endtask

`ifdef SPI_RX_FRAMER_TIMESTAMP_EN
    task automatic test_timestamp;
        beat_t exp_b;
        m_tready = 1'b1;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        for (int i = 0; i < 100; i++) tick;
        send_frame(32'h71, 32'h72, 32'h73, 1'b1, 32'd100);
        for (int i = 101; i < 140; i++) begin
            if (m_tvalid && m_tready) begin
                n_checks++;
                exp_b = sb.pop_front();
                if (m_tdata !== exp_b.data || m_tdest !== exp_b.dest || obs_user !== exp_b.user)
                    $display("FAIL ts_beat got %h/%0d user=%0d want %h/%0d user=%0d", m_tdata, m_tdest, obs_user,
                             exp_b.data, exp_b.dest, exp_b.user);
                else n_pass++;
            end
            tick;
        end
        send_frame(32'h81, 32'h82, 32'h83, 1'b1, 32'd140);
        for (int i = 0; i < 10 && sb.size() != 0; i++) begin
            if (m_tvalid && m_tready) begin
                n_checks++;
                exp_b = sb.pop_front();
                if (m_tdata !== exp_b.data || m_tdest !== exp_b.dest || obs_user !== exp_b.user)
                    $display("FAIL ts_beat got %h/%0d user=%0d want %h/%0d user=%0d", m_tdata, m_tdest, obs_user,
                             exp_b.data, exp_b.dest, exp_b.user);
                else n_pass++;
            end
            tick;
        end
        n_checks++; if (sb.size() != 0) $display("FAIL ts_drain left %0d beats want 0", sb.size()); else n_pass++;
    endtask
`endif

    initial begin
        data_in[0] = 32'd0;
        data_in[1] = 32'd0;
        data_in[2] = 32'd0;
        test_reset;
        test_single_frame;
        test_backpressure;
        test_back_to_back;
        test_overflow;
        test_reset_mid_frame;
`ifdef SPI_RX_FRAMER_TIMESTAMP_EN
        test_timestamp;
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
